// File: rtl/ustawianie_czasu_if.sv
// ustawianie_czasu_if: button/tick inputs and time/state outputs of the countdown timer.
interface ustawianie_czasu_if;
    logic [3:0] i_Przyciski_stan;
    logic       i_Przyciski_impuls;
    logic       i_Przyciski_przytrzymanie;
    logic       i_Odliczanie_impuls;
    logic       i_Odliczanie_przytrzymanie;
    logic       i_CE_1Hz;
    logic [6:0] o_Minuty;
    logic [5:0] o_Sekundy;
    logic [1:0] o_Stan;
    logic       o_Koniec;
    logic       o_Alarm;
    modport master (
        output i_Przyciski_stan, i_Przyciski_impuls, i_Przyciski_przytrzymanie,
               i_Odliczanie_impuls, i_Odliczanie_przytrzymanie, i_CE_1Hz,
        input  o_Minuty, o_Sekundy, o_Stan, o_Koniec, o_Alarm
    );
    modport slave (
        input  i_Przyciski_stan, i_Przyciski_impuls, i_Przyciski_przytrzymanie,
               i_Odliczanie_impuls, i_Odliczanie_przytrzymanie, i_CE_1Hz,
        output o_Minuty, o_Sekundy, o_Stan, o_Koniec, o_Alarm
    );
endinterface

// File: rtl/ustawianie_czasu.sv
// ustawianie_czasu: MM:SS countdown timer with set/start/pause/alarm FSM.
// Define AUTO_POWTARZANIE_EN to enable auto-repeat of held set buttons.
module ustawianie_czasu #(
    parameter int F_CLK  = 100_000_000,
    parameter int F_POWT = 10
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    ustawianie_czasu_if.slave  bus
);
    localparam int P = F_CLK / F_POWT;

    typedef enum logic [1:0] {USTAWIANIE, ODLICZANIE, PAUZA, KONIEC} stan_t;

    stan_t      state_q;
    logic [6:0] min_q, start_min_q, set_min_d;
    logic [5:0] sec_q, start_sec_q, set_sec_d;
    logic       koniec_q, alarm_q, hold_q;
    logic       rep_step, onehot, set_step, nonzero, at_one, hold_rise;

`ifdef AUTO_POWTARZANIE_EN
    localparam int CW = $clog2(P + 1);
    logic [CW-1:0] cnt_q;
    assign rep_step = bus.i_Przyciski_przytrzymanie && (cnt_q == CW'(P - 1));
    always_ff @(posedge i_CLK) begin
        if (i_RST || !bus.i_Przyciski_przytrzymanie)
            cnt_q <= '0;
        else
            cnt_q <= rep_step ? '0 : cnt_q + 1'b1;
    end
`else
    logic unused_rep;
    assign rep_step   = 1'b0;
    assign unused_rep = &{1'b0, bus.i_Przyciski_przytrzymanie, P[0]};
`endif

    // Bit order {IS,DS,IM,DM}; only a single pressed button steps the time.
    assign onehot    = (bus.i_Przyciski_stan != 4'd0) &&
                       ((bus.i_Przyciski_stan & (bus.i_Przyciski_stan - 4'd1)) == 4'd0);
    assign set_step  = onehot && (bus.i_Przyciski_impuls || rep_step);
    assign nonzero   = (min_q != 7'd0) || (sec_q != 6'd0);
    assign at_one    = (min_q == 7'd0) && (sec_q == 6'd1);
    assign hold_rise = bus.i_Odliczanie_przytrzymanie && !hold_q;

    always_comb begin
        set_sec_d = bus.i_Przyciski_stan[3] ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1) :
                    bus.i_Przyciski_stan[2] ? ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1) : sec_q;
        set_min_d = bus.i_Przyciski_stan[1] ? ((min_q == 7'd99) ? 7'd0 : min_q + 7'd1) :
                    bus.i_Przyciski_stan[0] ? ((min_q == 7'd0) ? 7'd99 : min_q - 7'd1) : min_q;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= USTAWIANIE;
            min_q       <= '0;
            sec_q       <= '0;
            start_min_q <= '0;
            start_sec_q <= '0;
            koniec_q    <= 1'b0;
            alarm_q     <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            koniec_q <= 1'b0;
            hold_q   <= bus.i_Odliczanie_przytrzymanie;
            if (hold_rise) begin
                state_q <= USTAWIANIE;
                min_q   <= '0;
                sec_q   <= '0;
                alarm_q <= 1'b0;
            end else begin
                case (state_q)
                    USTAWIANIE: begin
                        if (bus.i_Odliczanie_impuls && nonzero) begin
                            state_q     <= ODLICZANIE;
                            start_min_q <= min_q;
                            start_sec_q <= sec_q;
                        end else if (set_step) begin
                            min_q <= set_min_d;
                            sec_q <= set_sec_d;
                        end
                    end
                    ODLICZANIE: begin
                        // Reaching zero wins over a coincident pause request.
                        if (bus.i_CE_1Hz && at_one) begin
                            sec_q    <= '0;
                            state_q  <= KONIEC;
                            koniec_q <= 1'b1;
                            alarm_q  <= 1'b1;
                        end else begin
                            if (bus.i_CE_1Hz) begin
                                min_q <= (sec_q == 6'd0) ? min_q - 7'd1 : min_q;
                                sec_q <= (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                            end
                            if (bus.i_Odliczanie_impuls)
                                state_q <= PAUZA;
                        end
                    end
                    PAUZA: begin
                        if (bus.i_Odliczanie_impuls)
                            state_q <= ODLICZANIE;
                    end
                    KONIEC: begin
                        if (bus.i_Odliczanie_impuls) begin
                            state_q <= USTAWIANIE;
                            min_q   <= start_min_q;
                            sec_q   <= start_sec_q;
                            alarm_q <= 1'b0;
                        end
                    end
                    default: state_q <= USTAWIANIE;
                endcase
            end
        end
    end

    assign bus.o_Minuty  = min_q;
    assign bus.o_Sekundy = sec_q;
    assign bus.o_Stan    = state_q;
    assign bus.o_Koniec  = koniec_q;
    assign bus.o_Alarm   = alarm_q;
endmodule

// File: doc/ustawianie_czasu.md
USTAWIANIE_CZASU -- requirements
Module: ustawianie_czasu

Interface
REQ-001 Parameter F_CLK, 100_000_000, input clock frequency in Hz.
REQ-002 Parameter F_POWT, 10, auto-repeat step rate in Hz; repeat period P = F_CLK/F_POWT cycles.
REQ-003 i_CLK  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_RST  in  1  reset, synchronous, active-high.
REQ-005 i_Przyciski_stan  in  4  debounced level {IS,DS,IM,DM}: inc sec, dec sec, inc min, dec min.
REQ-006 i_Przyciski_impuls  in  1  one-cycle pulse, any set button newly pressed.
REQ-007 i_Przyciski_przytrzymanie  in  1  level, a set button held for 2 s or longer.
REQ-008 i_Odliczanie_impuls  in  1  one-cycle pulse, start/pause button pressed.
REQ-009 i_Odliczanie_przytrzymanie  in  1  level, start/pause button held for 2 s or longer.
REQ-010 i_CE_1Hz  in  1  one-cycle 1 Hz tick.
REQ-011 o_Minuty  out  7  minutes, 0..99 binary.
REQ-012 o_Sekundy  out  6  seconds, 0..59 binary.
REQ-013 o_Stan  out  2  0 USTAWIANIE, 1 ODLICZANIE, 2 PAUZA, 3 KONIEC.
REQ-014 o_Koniec  out  1  one-cycle pulse on reaching 00:00.
REQ-015 o_Alarm  out  1  high while in KONIEC.

Function
REQ-016 A set step SHALL apply only in USTAWIANIE and only when exactly one bit of i_Przyciski_stan is 1; otherwise it is ignored.
REQ-017 i_Przyciski_impuls SHALL apply one step, with the result visible on the next edge.
REQ-018 Steps: sec 59->0 and 0->59 on wrap, min 99->0 and 0->99 on wrap; no carry between fields.
REQ-019 Auto-repeat: a counter SHALL count while i_Przyciski_przytrzymanie=1 and SHALL apply one step each P cycles, the first step P cycles after the rise; the counter clears when the input is low.
REQ-020 i_Odliczanie_impuls transitions: USTAWIANIE->ODLICZANIE only if the time is nonzero, saving the time into the start register; at 00:00 the state is unchanged.
REQ-021 Further i_Odliczanie_impuls transitions: ODLICZANIE->PAUZA; PAUZA->ODLICZANIE; KONIEC->USTAWIANIE with the start register restored to the time.
REQ-022 A rising edge of i_Odliczanie_przytrzymanie in any state SHALL go to USTAWIANIE with time 00:00; it has priority over a same-cycle i_Odliczanie_impuls.
REQ-023 In ODLICZANIE, i_CE_1Hz SHALL decrement the time: sec>0 gives sec-1; sec=0 gives min-1 and sec=59.
REQ-024 A tick at 00:01 SHALL set the time to 00:00 and the state to KONIEC, and o_Koniec=1 for exactly that one cycle.
REQ-025 i_CE_1Hz SHALL be ignored in USTAWIANIE, PAUZA and KONIEC; set inputs SHALL be ignored outside USTAWIANIE.
REQ-026 If i_CE_1Hz and i_Odliczanie_impuls occur in the same cycle in ODLICZANIE, the decrement applies and the state becomes PAUZA.
REQ-027 If i_Przyciski_impuls and a repeat step coincide, exactly one step SHALL apply.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 i_RST=1 SHALL set state USTAWIANIE, time 00:00, start register 0, repeat counter 0, and o_Koniec=o_Alarm=0 on the next edge, including mid-countdown.
REQ-030 Reset SHALL have priority over all other inputs.

Configuration
REQ-031 With macro AUTO_POWTARZANIE_EN defined, auto-repeat is implemented as in REQ-019.
REQ-032 Without AUTO_POWTARZANIE_EN, no repeat counter SHALL exist, i_Przyciski_przytrzymanie is ignored, and only impulses step the time.

Verification (F_CLK=100, F_POWT=10, so P=10)
REQ-033 Reset, then IS impulse x3 and IM impulse x1 -> 01:03, o_Stan=0.
REQ-034 At 00:00: DS impulse -> 00:59; DM impulse -> 99:59; IS at 99:59 -> 99:00.
REQ-035 Hold IM with przytrzymanie=1 for 35 cycles -> exactly 3 extra minute steps; same with two stan bits set -> no change; without the macro -> no change.
REQ-036 Set 00:02, start, two ticks -> 00:01 then 00:00; o_Koniec is a 1-cycle pulse, o_Stan=3, o_Alarm=1; start impulse -> o_Stan=0, time 00:02.
REQ-037 Set 01:00, start, one tick -> 00:59; start impulse -> PAUZA, ticks ignored; start impulse -> ODLICZANIE.
REQ-038 Mid-countdown, assert i_RST one cycle -> 00:00, o_Stan=0; start impulse at 00:00 -> stays USTAWIANIE.
